uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb_pkg.sv | 18 +
 rtl/uart_tx_arb_rr_arbiter.sv | 38 +++
 rtl/uart_tx_arb.sv | 155 +++++++++++++++
 tb/tb_uart_tx_arb.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Optional packet tagging is enabled by defining UART_TX_ARB_TAG_EN.
package uart_tx_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
`ifdef UART_TX_ARB_TAG_EN
        TAG,
`endif
        SEND,
        WAIT_HI,
        WAIT_LO
    } state_e;

    localparam logic [7:0]  TAG_BASE        = 8'hF0;
    localparam int unsigned WAIT_HI_TIMEOUT = 2;

endpackage

// File: rtl/uart_tx_arb_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past ptr_i and wraps.
// No configuration macros (UART_TX_ARB_TAG_EN is not used here).
module rr_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o
);

    logic found;

    // Two constant-index passes: indices above the pointer first, then the wrap.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req_i[i] && (i > 32'(ptr_i))) begin
                found    = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = IDW'(i);
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req_i[i] && (i <= 32'(ptr_i))) begin
                found    = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-granular round-robin arbiter feeding one UART transmitter.
// Define UART_TX_ARB_TAG_EN to prefix each packet with an 8'hF0|id tag byte.
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_busy,
    output logic              grant_active,
    output logic [IDW-1:0]    grant_id
);

    state_e          state_q, state_d;
    logic            grant_active_q, grant_active_d;
    logic [IDW-1:0]  grant_id_q, grant_id_d;
    logic [IDW-1:0]  last_grant_q, last_grant_d;
    logic            last_q, last_d;
    logic [1:0]      wait_cnt_q, wait_cnt_d;

    logic [NREQ-1:0] arb_gnt;
    logic [IDW-1:0]  arb_idx;
    logic            sel_valid;
    logic [7:0]      sel_data;
    logic            sel_last;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req_i (req_valid),
        .ptr_i (last_grant_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        sel_last  = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_id_q == IDW'(i)) begin
                sel_valid = req_valid[i];
                sel_data  = req_data[8*i +: 8];
                sel_last  = req_last[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            grant_active_q <= 1'b0;
            grant_id_q     <= '0;
            last_grant_q   <= IDW'(NREQ - 1);
            last_q         <= 1'b0;
            wait_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            grant_active_q <= grant_active_d;
            grant_id_q     <= grant_id_d;
            last_grant_q   <= last_grant_d;
            last_q         <= last_d;
            wait_cnt_q     <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        grant_active_d = grant_active_q;
        grant_id_d     = grant_id_q;
        last_grant_d   = last_grant_q;
        last_d         = last_q;
        wait_cnt_d     = '0;
        case (state_q)
            IDLE: begin
                if ((|arb_gnt) && !tx_busy) begin
                    grant_active_d = 1'b1;
                    grant_id_d     = arb_idx;
`ifdef UART_TX_ARB_TAG_EN
                    state_d        = TAG;
`else
                    state_d        = SEND;
`endif
                end
            end
`ifdef UART_TX_ARB_TAG_EN
            // A cleared last flag makes WAIT_LO continue into SEND after the tag.
            TAG: begin
                last_d  = 1'b0;
                state_d = WAIT_HI;
            end
`endif
            SEND: begin
                if (sel_valid) begin
                    last_d  = sel_last;
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (tx_busy || (wait_cnt_q == 2'(WAIT_HI_TIMEOUT - 1)))
                    state_d = WAIT_LO;
                else
                    wait_cnt_d = wait_cnt_q + 2'd1;
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    if (last_q) begin
                        grant_active_d = 1'b0;
                        last_grant_d   = grant_id_q;
                        state_d        = IDLE;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are gated by rst so an abandoned packet emits nothing in the reset cycle.
    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = '0;
        req_ready = '0;
        if (!rst) begin
            case (state_q)
`ifdef UART_TX_ARB_TAG_EN
                TAG: begin
                    tx_valid = 1'b1;
                    tx_data  = TAG_BASE | 8'(grant_id_q);
                end
`endif
                SEND: begin
                    if (sel_valid) begin
                        tx_valid = 1'b1;
                        tx_data  = sel_data;
                        for (int unsigned i = 0; i < NREQ; i++)
                            req_ready[i] = (grant_id_q == IDW'(i));
                    end
                end
                default: ;
            endcase
        end
    end

    assign grant_active = grant_active_q && !rst;
    assign grant_id     = rst ? '0 : grant_id_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb (NREQ=4); the tagged build is selected
// with UART_TX_ARB_TAG_EN and then runs the tag-specific scenario.
module tb_uart_tx_arb;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_busy;
    logic        grant_active;
    logic [1:0]  grant_id;

    uart_tx_arb #(.NREQ(4), .IDW(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_busy      (tx_busy),
        .grant_active (grant_active),
        .grant_id     (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Requester sources and a UART busy model (busy for 3 cycles after each start)
    logic [7:0] src_b[4][8];
    bit         src_l[4][8];
    int         src_len[4];
    int         src_pos[4];
    bit         src_en[4];
    int         busy_cnt;
    bit         stuck;
    int         cyc;

    logic       s_txv, s_ga;
    logic [7:0] s_txd;
    logic [3:0] s_rdy;
    logic [1:0] s_gid;

    logic [7:0] log_d[$];
    logic [1:0] log_id[$];
    logic [3:0] log_rdy[$];
    int         log_cyc[$];

    task automatic drive_src();
        for (int i = 0; i < 4; i++) begin
            if (src_en[i] && src_pos[i] < src_len[i]) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = src_b[i][src_pos[i]];
                req_last[i]        = src_l[i][src_pos[i]];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        s_txv = tx_valid; s_txd = tx_data; s_rdy = req_ready;
        s_ga  = grant_active; s_gid = grant_id;
        if (s_txv || s_rdy != 4'h0) begin
            chk("ready_onehot_with_txv", 32'($onehot0(s_rdy) && (s_rdy == 4'h0 || s_txv)), 32'd1);
`ifndef UART_TX_ARB_TAG_EN
            if (s_txv) chk("ready_matches_grant", s_rdy, 4'b0001 << s_gid);
`endif
            if (s_txv) begin
                log_d.push_back(s_txd); log_id.push_back(s_gid);
                log_rdy.push_back(s_rdy); log_cyc.push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (s_txv) busy_cnt = 3;
        else if (busy_cnt > 0) busy_cnt--;
        tx_busy = !stuck && (busy_cnt != 0);
        for (int i = 0; i < 4; i++) if (s_rdy[i]) src_pos[i]++;
        drive_src();
    endtask

    task automatic load(input int r, input int n, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3, input logic [3:0] lst);
        src_b[r][0] = b0; src_b[r][1] = b1; src_b[r][2] = b2; src_b[r][3] = b3;
        for (int k = 0; k < 4; k++) src_l[r][k] = lst[k];
        src_len[r] = n; src_pos[r] = 0; src_en[r] = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1; stuck = 1'b0; busy_cnt = 0; tx_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin src_len[i] = 0; src_pos[i] = 0; src_en[i] = 1'b1; end
        drive_src();
        cycle(); cycle();
        rst = 1'b0;
        log_d.delete(); log_id.delete(); log_rdy.delete(); log_cyc.delete();
    endtask

    task automatic run_until_log(input int n, input int budget, input string name);
        int t;
        t = 0;
        while (log_d.size() < n && t < budget) begin cycle(); t++; end
        chk(name, log_d.size(), n);
    endtask

`ifndef UART_TX_ARB_TAG_EN
    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  last;
        logic        busy;
        logic        e_txv;
        logic [7:0]  e_txd;
        logic [3:0]  e_rdy;
        logic        e_ga;
        logic [1:0]  e_gid;
    } vec_t;
    vec_t tbl[13];
`endif

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_busy = 1'b0;
        stuck = 1'b0; busy_cnt = 0; cyc = 0;
        for (int i = 0; i < 4; i++) begin src_len[i] = 0; src_pos[i] = 0; src_en[i] = 1'b0; end
        repeat (2) @(posedge clk);

`ifndef UART_TX_ARB_TAG_EN
        // Reset, then requester 0 sends 41,42,43(last) with tx_busy driven per row
        tbl[0]  = '{1'b1, 4'h0, 32'h00, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 2'd0};
        tbl[1]  = '{1'b0, 4'h1, 32'h41, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 2'd0};
        tbl[2]  = '{1'b0, 4'h1, 32'h41, 4'h0, 1'b0, 1'b1, 8'h41, 4'h1, 1'b1, 2'd0};
        tbl[3]  = '{1'b0, 4'h1, 32'h42, 4'h0, 1'b1, 1'b0, 8'h00, 4'h0, 1'b1, 2'd0};
        tbl[4]  = '{1'b0, 4'h1, 32'h42, 4'h0, 1'b1, 1'b0, 8'h00, 4'h0, 1'b1, 2'd0};
        tbl[5]  = '{1'b0, 4'h1, 32'h42, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 2'd0};
        tbl[6]  = '{1'b0, 4'h1, 32'h42, 4'h0, 1'b0, 1'b1, 8'h42, 4'h1, 1'b1, 2'd0};
        tbl[7]  = '{1'b0, 4'h1, 32'h43, 4'h1, 1'b1, 1'b0, 8'h00, 4'h0, 1'b1, 2'd0};
        tbl[8]  = '{1'b0, 4'h1, 32'h43, 4'h1, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 2'd0};
        tbl[9]  = '{1'b0, 4'h1, 32'h43, 4'h1, 1'b0, 1'b1, 8'h43, 4'h1, 1'b1, 2'd0};
        tbl[10] = '{1'b0, 4'h0, 32'h00, 4'h0, 1'b1, 1'b0, 8'h00, 4'h0, 1'b1, 2'd0};
        tbl[11] = '{1'b0, 4'h0, 32'h00, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 2'd0};
        tbl[12] = '{1'b0, 4'h0, 32'h00, 4'h0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 2'd0};
        for (int r = 0; r < 13; r++) begin
            @(posedge clk);
            #1;
            rst = tbl[r].rst; req_valid = tbl[r].valid; req_data = tbl[r].data;
            req_last = tbl[r].last; tx_busy = tbl[r].busy;
            #3;
            chk($sformatf("row%0d_tx_valid", r), tx_valid, tbl[r].e_txv);
            chk($sformatf("row%0d_req_ready", r), req_ready, tbl[r].e_rdy);
            chk($sformatf("row%0d_grant_active", r), grant_active, tbl[r].e_ga);
            chk($sformatf("row%0d_grant_id", r), grant_id, tbl[r].e_gid);
            if (tbl[r].e_txv || tbl[r].rst)
                chk($sformatf("row%0d_tx_data", r), tx_data, tbl[r].e_txd);
        end

        // Requesters 1 and 2 contend; 1 wins, then 2 wins the next contention
        do_reset();
        load(1, 4, 8'h11, 8'h12, 8'h13, 8'h14, 4'b1100);
        load(2, 2, 8'h21, 8'h22, 8'h00, 8'h00, 4'b0010);
        run_until_log(6, 300, "contend_count");
        begin
            logic [7:0] ed[6] = '{8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h14};
            logic [1:0] ei[6] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd1};
            for (int k = 0; k < 6 && k < log_d.size(); k++) begin
                chk($sformatf("contend_data%0d", k), log_d[k], ed[k]);
                chk($sformatf("contend_id%0d", k), log_id[k], ei[k]);
            end
        end

        // Requester 0 stalls mid-packet for 10 cycles while requester 3 waits
        do_reset();
        load(0, 3, 8'h01, 8'h02, 8'h03, 8'h00, 4'b0100);
        load(3, 1, 8'h31, 8'h00, 8'h00, 8'h00, 4'b0001);
        src_en[3] = 1'b0;
        begin
            int t, gap_bad;
            t = 0;
            while (src_pos[0] < 1 && t < 50) begin cycle(); t++; end
            chk("stall_first_byte", src_pos[0], 1);
            src_en[0] = 1'b0; src_en[3] = 1'b1;
            gap_bad = 0;
            for (int k = 0; k < 10; k++) begin
                cycle();
                if (s_txv || !s_ga || s_gid != 2'd0) gap_bad++;
            end
            chk("stall_gap_quiet", gap_bad, 0);
            src_en[0] = 1'b1;
        end
        run_until_log(4, 300, "stall_count");
        begin
            logic [7:0] ed[4] = '{8'h01, 8'h02, 8'h03, 8'h31};
            logic [1:0] ei[4] = '{2'd0, 2'd0, 2'd0, 2'd3};
            for (int k = 0; k < 4 && k < log_d.size(); k++) begin
                chk($sformatf("stall_data%0d", k), log_d[k], ed[k]);
                chk($sformatf("stall_id%0d", k), log_id[k], ei[k]);
            end
        end

        // Reset while waiting for tx_busy to fall abandons the packet
        do_reset();
        load(0, 3, 8'hA1, 8'hA2, 8'hA3, 8'h00, 4'b0100);
        load(1, 1, 8'hB1, 8'h00, 8'h00, 8'h00, 4'b0001);
        begin
            int t;
            t = 0;
            while (src_pos[0] < 1 && t < 50) begin cycle(); t++; end
            chk("rst_first_byte", src_pos[0], 1);
        end
        cycle();
        rst = 1'b1;
        log_d.delete(); log_id.delete(); log_rdy.delete(); log_cyc.delete();
        cycle();
        chk("rst_cycle_no_txv", s_txv, 1'b0);
        rst = 1'b0;
        cycle();
        chk("post_rst_grant_active", s_ga, 1'b0);
        chk("post_rst_no_txv", s_txv, 1'b0);
        run_until_log(3, 300, "post_rst_count");
        if (log_d.size() >= 3) begin
            chk("post_rst_winner", log_id[0], 2'd0);
            chk("post_rst_data0", log_d[0], 8'hA2);
            chk("post_rst_data2", log_d[2], 8'hB1);
        end

        // Transmitter never raises busy: WAIT_HI times out after 2 cycles
        do_reset();
        stuck = 1'b1;
        load(0, 2, 8'hC1, 8'hC2, 8'h00, 8'h00, 4'b0010);
        run_until_log(2, 100, "stuck_count");
        if (log_d.size() >= 2) begin
            chk("stuck_spacing", log_cyc[1] - log_cyc[0], 4);
            chk("stuck_data1", log_d[1], 8'hC2);
        end
        stuck = 1'b0;
`else
        do_reset();
        chk("reset_grant_active", s_ga, 1'b0);
        chk("reset_grant_id", s_gid, 2'd0);
        chk("reset_tx_valid", s_txv, 1'b0);
        chk("reset_tx_data", s_txd, 8'h00);
        chk("reset_req_ready", s_rdy, 4'h0);

        // Requester 2 sends one byte: tag F2 then 55, one req_ready pulse
        load(2, 1, 8'h55, 8'h00, 8'h00, 8'h00, 4'b0001);
        run_until_log(2, 100, "tag_count");
        if (log_d.size() >= 2) begin
            chk("tag_byte", log_d[0], 8'hF2);
            chk("tag_ready", log_rdy[0], 4'h0);
            chk("tag_id", log_id[0], 2'd2);
            chk("tag_payload", log_d[1], 8'h55);
            chk("tag_payload_ready", log_rdy[1], 4'b0100);
        end
        repeat (8) cycle();
        chk("tag_total_tx", log_d.size(), 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
